// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage: in-order imem requests, response FIFO, redirect flush
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        pc_v_x,
  input  logic [31:0] pc_x,
  output logic        inst_v_f,
  output logic [31:0] inst_f,
  output logic [31:0] pc_f
);
  localparam int          AW        = $clog2(DEPTH);
  localparam int          CW        = $clog2(MAX_OUT + 1);
  localparam logic [31:0] MAX_OUT_U = MAX_OUT;
  localparam logic [31:0] DEPTH_U   = DEPTH;
  localparam logic [AW:0] FULL_CNT  = (AW + 1)'(DEPTH);

  logic          started;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   last_pc;
  logic [31:0]   last_inst;
  logic [CW-1:0] live;
  logic [CW-1:0] kill;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic          fire;
  logic          drop;
  logic          push;
  logic          empty;
  logic [31:0]   redirect_pc;

  assign count       = wr_ptr - rd_ptr;
  assign empty       = (count == '0);
  assign redirect_pc = pc_x & ~32'h3;

  // Credits: bounded in-flight requests, and every kept response must find a free FIFO slot.
  assign imem_req  = started
                   && ((32'(live) + 32'(kill)) < MAX_OUT_U)
                   && ((32'(count) + 32'(live)) < DEPTH_U);
  assign imem_addr = fetch_pc;
  assign fire      = imem_req & imem_gnt;
  assign drop      = imem_rvalid & (kill != '0);
  assign push      = imem_rvalid & ~drop & ~pc_v_x;

  assign inst_v_f = ~empty & ~pc_v_x;
  assign pc_f     = empty ? last_pc   : pc_mem[rd_ptr[AW-1:0]];
  assign inst_f   = empty ? last_inst : inst_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started   <= 1'b0;
      fetch_pc  <= RESET_PC;
      resp_pc   <= RESET_PC;
      live      <= '0;
      kill      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_pc   <= '0;
      last_inst <= '0;
    end else begin
      started <= 1'b1;
      if (pc_v_x) begin
        // Everything in flight becomes wrong-path; one credit returns if a response lands now.
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        kill     <= kill + live + CW'(fire) - CW'(imem_rvalid);
        live     <= '0;
        rd_ptr   <= wr_ptr;
      end else begin
        if (fire) fetch_pc <= fetch_pc + 32'd4;
        live <= live + CW'(fire) - CW'(imem_rvalid & ~drop);
        if (drop) kill <= kill - CW'(1);
        if (push) begin
          wr_ptr  <= wr_ptr + 1'b1;
          resp_pc <= resp_pc + 32'd4;
        end
        if (inst_v_f) begin
          rd_ptr    <= rd_ptr + 1'b1;
          last_pc   <= pc_f;
          last_inst <= inst_f;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr[AW-1:0]]   <= resp_pc;
      inst_mem[wr_ptr[AW-1:0]] <= imem_rdata;
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && (count == FULL_CNT)));

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - randomized bench for fetch against an expected-instruction-stream model
module tb_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        pc_v_x = 1'b0;
  logic [31:0] pc_x = '0;
  logic        inst_v_f;
  logic [31:0] inst_f;
  logic [31:0] pc_f;

  fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_v_x(pc_v_x), .pc_x(pc_x),
    .inst_v_f(inst_v_f), .inst_f(inst_f), .pc_f(pc_f)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    int          rdy;
  } req_t;

  req_t        pend[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          idle = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          gnt_always = 1'b1;
  bit          gnt_low = 1'b0;
  bit          redir = 1'b0;
  bit          have_last = 1'b0;
  logic [31:0] redir_tgt = '0;
  logic [31:0] req_exp = RESET_PC;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] last_pc = '0;
  logic        s_req;
  logic        s_v;
  logic [31:0] s_addr;
  logic [31:0] s_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive memory/redirect, sample mid-cycle, check, advance the model.
  task automatic step();
    logic fire;
    req_t r;
    if (reset && pend.size() > 0 && pend[0].rdy <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    imem_gnt = gnt_low ? 1'b0 : (gnt_always ? 1'b1 : ($urandom_range(0, 3) != 0));
    pc_v_x   = reset & redir;
    pc_x     = redir ? redir_tgt : $urandom;
    #1;
    s_req  = imem_req;
    s_v    = inst_v_f;
    s_addr = imem_addr;
    s_pc   = pc_f;
    if (!reset) begin
      check("reset_req", 32'(imem_req), 32'd0);
      check("reset_valid", 32'(inst_v_f), 32'd0);
      check("reset_addr", imem_addr, RESET_PC);
      pend.delete();
      req_exp   = RESET_PC;
      exp_pc    = RESET_PC;
      have_last = 1'b0;
      idle      = 0;
    end else begin
      if (pc_v_x) check("redir_valid", 32'(inst_v_f), 32'd0);
      if (inst_v_f) begin
        check("pc_f", pc_f, exp_pc);
        check("inst_f", inst_f, mem_word(exp_pc));
        exp_pc    = exp_pc + 32'd4;
        last_pc   = pc_f;
        have_last = 1'b1;
        idle      = 0;
      end else begin
        if (!pc_v_x && have_last) check("hold_pc", pc_f, last_pc);
        idle++;
      end
      if (pc_v_x) idle = 0;
      if (idle == 40) check("stall_cycles", 32'(idle), 32'd0);
      if (imem_req) check("req_addr", imem_addr, req_exp);
      fire = imem_req & imem_gnt;
      if (fire) begin
        r.addr = imem_addr;
        r.rdy  = cyc + $urandom_range(lat_min, lat_max);
        pend.push_back(r);
        req_exp = req_exp + 32'd4;
        check("outstanding", 32'(pend.size() <= MAX_OUT), 32'd1);
      end
      if (imem_rvalid) void'(pend.pop_front());
      if (pc_v_x) begin
        exp_pc  = pc_x & ~32'h3;
        req_exp = pc_x & ~32'h3;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redir = 1'b0;
    repeat (2) step();
    reset = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] want);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (s_v) begin
        check(tag, s_pc, want);
        got = 1'b1;
      end
    end
    check({tag, "_seen"}, 32'(got), 32'd1);
  endtask

  initial begin
    int  first_req;
    int  first_v;
    int  streak;
    int  n_after;
    int  held;
    bit  done;
    bit  got;

    @(posedge clk);
    #1;
    repeat (3) step();

    // Single-cycle memory, always granting: back-to-back stream from RESET_PC.
    reset = 1'b1;
    first_req = -1; first_v = -1; streak = 0; n_after = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (s_req && first_req < 0) first_req = cyc - 1;
      if (s_v && first_v < 0) first_v = cyc - 1;
      if (first_v >= 0) begin
        n_after++;
        if (s_v) streak++;
      end
    end
    check("first_latency", 32'(first_v - first_req), 32'd2);
    check("streak", 32'(streak), 32'(n_after));

    // Grant withheld three cycles at 0x8.
    do_reset();
    held = 0;
    for (int i = 0; i < 20; i++) begin
      gnt_low = (req_exp == 32'h8) && (held < 3);
      step();
      if (gnt_low) begin
        check("hold_req", 32'(s_req), 32'd1);
        check("hold_addr", s_addr, 32'h8);
        held++;
      end
    end
    gnt_low = 1'b0;
    check("hold_cycles", 32'(held), 32'd3);

    // Redirect with 0x10/0x14 outstanding.
    do_reset();
    lat_min = 3; lat_max = 3;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      redir     = (req_exp == 32'h18) && (pend.size() == 2);
      redir_tgt = 32'h100;
      step();
      if (redir) done = 1'b1;
      redir = 1'b0;
    end
    check("t3_redirected", 32'(done), 32'd1);
    wait_valid("t3_pc", 32'h100);

    // Misaligned target.
    redir = 1'b1; redir_tgt = 32'h102;
    step();
    redir = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (s_req) begin
        check("t4_addr", s_addr, 32'h100);
        got = 1'b1;
      end
    end
    check("t4_req_seen", 32'(got), 32'd1);
    wait_valid("t4_pc", 32'h100);

    // Redirect in a cycle where a response arrives.
    lat_min = 1; lat_max = 1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      redir     = (pend.size() > 0) && (pend[0].rdy <= cyc);
      redir_tgt = 32'h200;
      step();
      if (redir) done = 1'b1;
      redir = 1'b0;
    end
    check("t5_redirected", 32'(done), 32'd1);
    wait_valid("t5_pc", 32'h200);

    // Reset mid-stream with two requests outstanding.
    lat_min = 3; lat_max = 3;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      step();
      done = (pend.size() == 2);
    end
    check("t6_two_out", 32'(done), 32'd1);
    do_reset();
    wait_valid("t6_pc", RESET_PC);

    // Random grants, latencies, redirects (incl. near wrap and misaligned) and resets.
    gnt_always = 1'b0;
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      redir = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       redir_tgt = $urandom;
        1:       redir_tgt = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
        2:       redir_tgt = 32'($urandom_range(0, 255));
        default: redir_tgt = exp_pc + 32'($urandom_range(0, 15));
      endcase
      step();
      redir = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
